// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch handshake, execute handshake, register-file
// read controls and the writeback retire port.
interface decode_stage_if;
    // fetch side
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    // register file read port controls
    logic [31:0] rs1_addr;
    logic [31:0] rs2_addr;
    logic        read_rs1;
    logic        read_rs2;
    // execute side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic [31:0] out_rd;
    logic        out_rd_write;
    logic [31:0] out_imm;
    logic        out_illegal;
    // writeback retire
    logic        wb_valid;
    logic [4:0]  wb_rd;

    // decode stage view
    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_rd,
        output in_ready, rs1_addr, rs2_addr, read_rs1, read_rs2,
               out_valid, out_pc, out_opcode, out_funct3, out_funct7b5,
               out_rd, out_rd_write, out_imm, out_illegal
    );

    // fetch / execute / writeback environment view
    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready, wb_valid, wb_rd,
        input  in_ready, rs1_addr, rs2_addr, read_rs1, read_rs2,
               out_valid, out_pc, out_opcode, out_funct3, out_funct7b5,
               out_rd, out_rd_write, out_imm, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: cracks one instruction per cycle, steers the
// synchronous register file read port and tracks in-flight writers in a
// pending-write scoreboard so no source is read before it is written back.
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // instruction fields
    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

    assign w_instr  = bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s  = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                       w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u  = {w_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                       w_instr[20], w_instr[30:21], 1'b0};

    // decoded controls
    logic        w_uses_rs1, w_uses_rs2, w_writes_class, w_illegal;
    logic        w_rd_write;
    logic [31:0] w_imm;

    // held bundle
    logic        r_valid;
    logic [31:0] r_pc;
    logic [6:0]  r_opcode;
    logic [2:0]  r_funct3;
    logic        r_funct7b5;
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic        r_rd_write, r_read_rs1, r_read_rs2, r_illegal;
    logic [31:0] r_imm;

    // scoreboard: bit 0 is never stored, x0 is always ready
    logic [31:1] r_sb;
    logic [31:0] w_sb;
    logic [31:0] w_sb_next;
    logic        w_hazard, w_in_ready, w_accept;

    assign w_sb = {r_sb, 1'b0};

    // opcode class decode: source usage, write class, immediate format
    always_comb begin
        w_uses_rs1     = 1'b0;
        w_uses_rs2     = 1'b0;
        w_writes_class = 1'b0;
        w_illegal      = 1'b0;
        w_imm          = 32'h0;
        case (w_opcode)
            OP_LUI:    begin w_writes_class = 1'b1; w_imm = w_imm_u; end
            OP_AUIPC:  begin w_writes_class = 1'b1; w_imm = w_imm_u; end
            OP_JAL:    begin w_writes_class = 1'b1; w_imm = w_imm_j; end
            OP_JALR:   begin w_writes_class = 1'b1; w_uses_rs1 = 1'b1; w_imm = w_imm_i; end
            OP_BRANCH: begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_imm = w_imm_b; end
            OP_LOAD:   begin w_writes_class = 1'b1; w_uses_rs1 = 1'b1; w_imm = w_imm_i; end
            OP_STORE:  begin w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; w_imm = w_imm_s; end
            OP_OPIMM:  begin w_writes_class = 1'b1; w_uses_rs1 = 1'b1; w_imm = w_imm_i; end
            OP_OP:     begin w_writes_class = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1; end
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_rd_write = w_writes_class & (w_rd != 5'd0);

    // RAW on either source or WAW on rd against the registered scoreboard;
    // a same-cycle writeback is not bypassed, the dependent waits one cycle
    assign w_hazard   = (w_uses_rs1 & w_sb[w_rs1]) |
                        (w_uses_rs2 & w_sb[w_rs2]) |
                        (w_rd_write & w_sb[w_rd]);
    assign w_in_ready = (~r_valid | bus.out_ready) & ~w_hazard & ~bus.flush;
    assign w_accept   = bus.in_valid & w_in_ready;

    // scoreboard next state: clears first, so a same-index set wins
    always_comb begin
        w_sb_next = w_sb;
        if (bus.wb_valid)
            w_sb_next[bus.wb_rd] = 1'b0;
        if (bus.flush && r_valid && r_rd_write)
            w_sb_next[r_rd] = 1'b0;
        if (w_accept && w_rd_write)
            w_sb_next[w_rd] = 1'b1;
    end

    // scoreboard register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_sb <= '0;
        else        r_sb <= w_sb_next[31:1];
    end

    // bundle valid: flush kills, accept fills, consumption drains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              r_valid <= 1'b0;
        else if (bus.flush)      r_valid <= 1'b0;
        else if (w_accept)       r_valid <= 1'b1;
        else if (bus.out_ready)  r_valid <= 1'b0;
    end

    // bundle payload only changes on accept, so a stalled bundle stays put
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_opcode   <= '0;
            r_funct3   <= '0;
            r_funct7b5 <= 1'b0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd_write <= 1'b0;
            r_read_rs1 <= 1'b0;
            r_read_rs2 <= 1'b0;
            r_illegal  <= 1'b0;
            r_imm      <= '0;
        end else if (w_accept) begin
            r_pc       <= bus.in_pc;
            r_opcode   <= w_opcode;
            r_funct3   <= w_instr[14:12];
            r_funct7b5 <= w_instr[30];
            r_rd       <= w_rd;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd_write <= w_rd_write;
            r_read_rs1 <= w_uses_rs1;
            r_read_rs2 <= w_uses_rs2;
            r_illegal  <= w_illegal;
            r_imm      <= w_imm;
        end
    end

    // register file is addressed with the incoming sources on accept and
    // re-reads the held sources otherwise, keeping its data aligned to out_valid
    assign bus.rs1_addr = {27'b0, w_accept ? w_rs1 : r_rs1};
    assign bus.rs2_addr = {27'b0, w_accept ? w_rs2 : r_rs2};
    assign bus.read_rs1 = w_accept ? w_uses_rs1 : r_read_rs1;
    assign bus.read_rs2 = w_accept ? w_uses_rs2 : r_read_rs2;

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_opcode   = r_opcode;
    assign bus.out_funct3   = r_funct3;
    assign bus.out_funct7b5 = r_funct7b5;
    assign bus.out_rd       = {27'b0, r_rd};
    assign bus.out_rd_write = r_rd_write;
    assign bus.out_imm      = r_imm;
    assign bus.out_illegal  = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a behavioural model predicts in_ready,
// register-file addressing and each decoded bundle; a monitor checks bundles.
module tb_decode_stage;
    localparam logic [31:0] RST_PC = 32'h8000_0040;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        rdw;
        logic        ur1;
        logic        ur2;
        logic        ill;
        logic [31:0] imm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if bus();
    decode_stage #(.RESET_PC(RST_PC)) dut (.clk(clk), .reset(reset), .bus(bus));

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    logic [31:0] m_sb;
    logic        m_valid;
    exp_t        m_held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference decode from the instruction-class tables and immediate formats
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t d;
        logic wr;
        d = '0;
        d.pc = pc; d.op = i[6:0]; d.f3 = i[14:12]; d.f7 = i[30];
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20];
        wr = 1'b0;
        case (i[6:0])
            7'h37, 7'h17: begin wr = 1'b1; d.imm = {i[31:12], 12'h000}; end
            7'h6F: begin wr = 1'b1; d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin wr = 1'b1; d.ur1 = 1'b1; d.imm = 32'($signed(i[31:20])); end
            7'h63: begin d.ur1 = 1'b1; d.ur2 = 1'b1;
                         d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h03: begin wr = 1'b1; d.ur1 = 1'b1; d.imm = 32'($signed(i[31:20])); end
            7'h23: begin d.ur1 = 1'b1; d.ur2 = 1'b1; d.imm = 32'($signed({i[31:25], i[11:7]})); end
            7'h13: begin wr = 1'b1; d.ur1 = 1'b1; d.imm = 32'($signed(i[31:20])); end
            7'h33: begin wr = 1'b1; d.ur1 = 1'b1; d.ur2 = 1'b1; end
            default: d.ill = 1'b1;
        endcase
        d.rdw = wr && (d.rd != 5'd0);
        return d;
    endfunction

    // one clock cycle: drive, predict and check at the falling edge, advance model
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic fl, input logic ordy, input logic wbv, input logic [4:0] wbr);
        exp_t d;
        logic hz, rdy, acc;
        logic [31:0] nsb;
        bus.in_valid = v; bus.in_instr = instr; bus.in_pc = pc; bus.flush = fl;
        bus.out_ready = ordy; bus.wb_valid = wbv; bus.wb_rd = wbr;
        @(negedge clk);
        d   = ref_decode(instr, pc);
        hz  = (d.ur1 && m_sb[d.rs1]) || (d.ur2 && m_sb[d.rs2]) || (d.rdw && m_sb[d.rd]);
        rdy = (!m_valid || ordy) && !hz && !fl;
        acc = v && rdy;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("rs1_addr", bus.rs1_addr, {27'b0, acc ? d.rs1 : m_held.rs1});
        chk("rs2_addr", bus.rs2_addr, {27'b0, acc ? d.rs2 : m_held.rs2});
        chk("read_rs1", 32'(bus.read_rs1), 32'(acc ? d.ur1 : m_held.ur1));
        chk("read_rs2", 32'(bus.read_rs2), 32'(acc ? d.ur2 : m_held.ur2));
        if (acc) q.push_back(d);
        nsb = m_sb;
        if (wbv) nsb[wbr] = 1'b0;
        if (fl && m_valid && m_held.rdw) nsb[m_held.rd] = 1'b0;
        if (acc && d.rdw) nsb[d.rd] = 1'b1;
        @(posedge clk);
        m_sb = nsb;
        m_valid = fl ? 1'b0 : acc ? 1'b1 : ordy ? 1'b0 : m_valid;
        if (acc) m_held = d;
        #1;
    endtask

    // asynchronous reset in the middle of a cycle, checked before the next edge
    task automatic do_reset();
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.wb_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_pc", bus.out_pc, RST_PC);
        chk("rst_out_imm", bus.out_imm, 32'd0);
        chk("rst_out_rd_write", 32'(bus.out_rd_write), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        chk("rst_out_opcode", 32'(bus.out_opcode), 32'd0);
        chk("rst_rs1_addr", bus.rs1_addr, 32'd0);
        m_sb = '0; m_valid = 1'b0; m_held = '0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // monitor: compare every presented bundle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL monitor: out_valid=1 with no expected bundle pending");
                end else begin
                    e = q[0];
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_opcode", 32'(bus.out_opcode), 32'(e.op));
                    chk("out_funct3", 32'(bus.out_funct3), 32'(e.f3));
                    chk("out_funct7b5", 32'(bus.out_funct7b5), 32'(e.f7));
                    chk("out_rd_write", 32'(bus.out_rd_write), 32'(e.rdw));
                    if (e.rdw) chk("out_rd", bus.out_rd, {27'b0, e.rd});
                    chk("out_imm", bus.out_imm, e.imm);
                    chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
                    if (bus.out_ready || bus.flush) e = q.pop_front();
                end
            end
        end
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    initial begin
        logic [31:0] instr, rnd;
        int r;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.flush = 1'b0;
        bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0;
        m_sb = '0; m_valid = 1'b0; m_held = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_out_pc", bus.out_pc, RST_PC);
        chk("init_out_imm", bus.out_imm, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // addi x5,x0,-1 then dependent add x6,x5,x5 waiting for writeback
        step(1, 32'hFFF00293, 32'h100, 0, 1, 0, 0);
        step(1, 32'h00528333, 32'h104, 0, 1, 0, 0);
        step(1, 32'h00528333, 32'h104, 0, 1, 1, 5);
        step(1, 32'h00528333, 32'h104, 0, 1, 0, 0);
        // beq x1,x2,-4
        step(1, 32'hFE208EE3, 32'h108, 0, 1, 0, 0);
        // hold beq for 3 cycles with xor x11,x1,x2 waiting, then accept
        repeat (3) step(1, 32'h0020C5B3, 32'h10C, 0, 0, 0, 0);
        step(1, 32'h0020C5B3, 32'h10C, 0, 1, 0, 0);
        // lw x7 held, flushed, then x7 is free again
        step(1, 32'h0000A383, 32'h110, 0, 1, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);
        step(1, 32'h00300393, 32'h114, 0, 1, 0, 0);
        // writeback of x9 in the same cycle as accept of a new x9 writer
        step(1, 32'h00100493, 32'h118, 0, 1, 1, 9);
        step(1, 32'h00048513, 32'h11C, 0, 1, 0, 0);
        step(1, 32'h00048513, 32'h11C, 0, 1, 1, 9);
        step(1, 32'h00048513, 32'h11C, 0, 1, 0, 0);
        // illegal opcode, stall, then reset mid-stall
        step(1, 32'h0000007F, 32'h120, 0, 1, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0);
        do_reset();

        // randomized traffic over a small register window to provoke hazards
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            instr = $urandom;
            rnd = $urandom;
            instr[6:0] = ops[r];
            if (r == 9 && rnd[0]) instr[6:0] = {rnd[5:1], 2'b01};
            instr[11:7]  = 5'($urandom_range(0, 7));
            instr[19:15] = 5'($urandom_range(0, 7));
            instr[24:20] = 5'($urandom_range(0, 7));
            if (n == 300) do_reset();
            step($urandom_range(0, 3) != 0, instr, $urandom,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
        end

        // drain
        repeat (4) step(0, 32'h0, 32'h0, 0, 1, 0, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

RV32I instruction decode stage between fetch and execute. Accepts one instruction per cycle over a valid/ready handshake and cracks it into register indices, a sign-extended immediate and control fields. Drives the synchronous-read register file's address and read-enable inputs, and keeps a 32-entry pending-write scoreboard so a source is never read before its in-flight writer retires. Decoded bundle and register-file read data emerge in the same cycle.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value of out_pc while out_valid=0 after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  kill held bundle; block new accepts this cycle
- rs1_addr  out  32  register file rs1 index; bits [31:5] always 0
- rs2_addr  out  32  register file rs2 index; bits [31:5] always 0
- read_rs1  out  1  instruction uses rs1
- read_rs2  out  1  instruction uses rs2
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- out_pc  out  32  PC of bundle
- out_opcode  out  7  instr[6:0]
- out_funct3  out  3  instr[14:12]
- out_funct7b5  out  1  instr[30]
- out_rd  out  32  destination index; bits [31:5] 0
- out_rd_write  out  1  bundle writes rd (never for rd=0)
- out_imm  out  32  sign-extended immediate
- out_illegal  out  1  unsupported encoding
- wb_valid  in  1  writeback retires a register write this cycle
- wb_rd  in  5  register being written back

## Operation
- Classes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011. Anything else, or instr[1:0]!=2'b11: illegal, rd_write=0, reads=0, imm=0.
- rs1 used: JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 used: BRANCH, STORE, OP. rd_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and rd!=0.
- Immediates: I={20{i[31]},i[31:20]}; S={20{i[31]},i[31:25],i[11:7]}; B={19{i[31]},i[31],i[7],i[30:25],i[11:8],1'b0}; U={i[31:12],12'b0}; J={11{i[31]},i[31],i[19:12],i[20],i[30:21],1'b0}. R-type imm=0.
- Scoreboard sb[31:0], registered, sb[0] hardwired 0. hazard = (uses_rs1 & sb[rs1]) | (uses_rs2 & sb[rs2]) | (rd_write & sb[rd]).
- in_ready = (!out_valid | out_ready) & !hazard & !flush. accept = in_valid & in_ready.
- On accept: bundle registered, out_valid=1, sb[rd] set if rd_write.
- Retire: wb_valid clears sb[wb_rd] at the edge. Same-cycle set and clear of same index: set wins.
- flush: out_valid->0 next edge; if held bundle has out_rd_write, its sb bit cleared (in addition to any wb clear). No accept in flush cycle.
- out_valid & !out_ready: bundle and all outputs held stable.

## Timing
- rs1_addr/rs2_addr/read_* are combinational: from in_instr fields when accept=1, else from the held bundle, so register file re-reads the held sources every stall cycle and its rs1/rs2 outputs align with out_valid.
- Accept at edge N -> out_valid and valid register-file data from cycle N+1. Throughput 1/cycle absent hazards.
- Write-after-read in register file returns old value; scoreboard clear is registered, so a dependent waits until the cycle after wb_valid, and its read then sees the new value. No bypass.
- Reset (async, any cycle): out_valid=0, sb=0, out_pc=RESET_PC, all other bundle outputs 0, in_ready=1 once reset deasserts if no flush. In-flight bundle discarded.

## Test plan
- addi x5,x0,-1 (0xFFF00293) with out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_rd=5, out_rd_write=1, read_rs1=1, read_rs2=0; sb[5]=1.
- Back-to-back add x6,x5,x5 after it -> in_ready=0 until cycle after wb_valid,wb_rd=5; then accepted, rs1_addr=rs2_addr=5.
- beq x1,x2,-4 (0xFE208EE3) -> out_imm=0xFFFFFFFC, out_rd_write=0, read_rs1=read_rs2=1, sb unchanged.
- out_ready=0 for 3 cycles with bundle held -> outputs and rs*_addr stable, in_ready=0; then out_ready=1 accepts next instruction same cycle.
- flush while held lw x7 pending -> out_valid=0 next cycle, sb[7]=0; wb_valid,wb_rd=9 simultaneous with accept of rd=9 -> sb[9]=1.
- Opcode 0x0000007F and reset asserted mid-stall -> out_illegal=1, out_rd_write=0; reset clears out_valid and sb immediately.
